// File: rtl/vending_ctrl.sv
// Vending controller: accumulates coin credit against PRICE, pulses soda, returns change or refunds as coins.
// All outputs registered, one-cycle credit/vend latency; an offered coin holds until disp_ready is seen.
module vending_ctrl #(
  parameter int PRICE = 4,
  localparam int CW = $clog2(PRICE + 5) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          nickel,
  input  logic          dime,
  input  logic          quarter,
  input  logic          cancel,
  output logic          soda,
  output logic [CW-1:0] change,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          coin_rej,
  output logic          disp_valid,
  output logic [1:0]    disp_coin,
  input  logic          disp_ready
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_DISPENSE} state_t;

  localparam logic [CW-1:0] PRICE_U = CW'(PRICE);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] change_q, change_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          soda_q, soda_d;
  logic          rej_q, rej_d;
  logic          dv_q, dv_d;
  logic [1:0]    dc_q, dc_d;

  logic [CW-1:0] value, sum, left;
  logic          multi, any_coin;

  function automatic logic [1:0] pick(input logic [CW-1:0] amt);
    if (amt >= CW'(5)) return 2'b11;
    else if (amt >= CW'(2)) return 2'b10;
    else return 2'b01;
  endfunction

  function automatic logic [CW-1:0] coin_units(input logic [1:0] c);
    case (c)
      2'b11:   return CW'(5);
      2'b10:   return CW'(2);
      2'b01:   return CW'(1);
      default: return '0;
    endcase
  endfunction

  // Simultaneous strobes are worth nothing and are flagged as a reject.
  always_comb begin
    value = '0;
    multi = 1'b0;
    case ({nickel, dime, quarter})
      3'b000:  value = '0;
      3'b100:  value = CW'(1);
      3'b010:  value = CW'(2);
      3'b001:  value = CW'(5);
      default: multi = 1'b1;
    endcase
  end

  assign any_coin = nickel | dime | quarter;
  assign sum      = credit_q + value;
  assign left     = remain_q - coin_units(dc_q);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = '0;
    remain_d = remain_q;
    soda_d   = 1'b0;
    rej_d    = multi;
    dv_d     = dv_q;
    dc_d     = dc_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel && sum != '0) begin
          state_d  = S_DISPENSE;
          remain_d = sum;
          credit_d = '0;
          dv_d     = 1'b1;
          dc_d     = pick(sum);
        end else if (sum >= PRICE_U) begin
          state_d  = S_VEND;
          soda_d   = 1'b1;
          change_d = sum - PRICE_U;
          credit_d = '0;
        end else if (sum != '0) begin
          state_d  = S_COLLECT;
          credit_d = sum;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_VEND: begin
        rej_d = any_coin;
        if (change_q != '0) begin
          state_d  = S_DISPENSE;
          remain_d = change_q;
          dv_d     = 1'b1;
          dc_d     = pick(change_q);
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_DISPENSE: begin
        rej_d = any_coin;
        if (disp_ready && dv_q) begin
          remain_d = left;
          if (left == '0) begin
            state_d = S_IDLE;
            dv_d    = 1'b0;
            dc_d    = 2'b00;
          end else begin
            dc_d    = pick(left);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      change_q <= '0;
      remain_q <= '0;
      soda_q   <= 1'b0;
      rej_q    <= 1'b0;
      dv_q     <= 1'b0;
      dc_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      remain_q <= remain_d;
      soda_q   <= soda_d;
      rej_q    <= rej_d;
      dv_q     <= dv_d;
      dc_q     <= dc_d;
    end
  end

  assign soda       = soda_q;
  assign change     = change_q;
  assign credit     = credit_q;
  assign busy       = (state_q == S_VEND) || (state_q == S_DISPENSE);
  assign coin_rej   = rej_q;
  assign disp_valid = dv_q;
  assign disp_coin  = dc_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: two instances (PRICE=4 and PRICE=13) share stimulus and are checked
// every cycle against a coin-list model, plus directed scenarios with literal expectations.
module tb_vending_ctrl;

  logic clk, rst_n;
  logic nickel, dime, quarter, cancel, disp_ready;

  logic       soda_a, busy_a, rej_a, dv_a;
  logic [4:0] change_a, credit_a;
  logic [1:0] dc_a;
  logic       soda_b, busy_b, rej_b, dv_b;
  logic [5:0] change_b, credit_b;
  logic [1:0] dc_b;

  int n_checks = 0;
  int n_fail   = 0;

  vending_ctrl #(.PRICE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .cancel(cancel), .soda(soda_a), .change(change_a), .credit(credit_a),
    .busy(busy_a), .coin_rej(rej_a), .disp_valid(dv_a), .disp_coin(dc_a),
    .disp_ready(disp_ready)
  );

  vending_ctrl #(.PRICE(13)) dut_b (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .cancel(cancel), .soda(soda_b), .change(change_b), .credit(credit_b),
    .busy(busy_b), .coin_rej(rej_b), .disp_valid(dv_b), .disp_coin(dc_b),
    .disp_ready(disp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: credit in units, a pending vend with its change, and the list of coins still owed.
  int m_credit [2];
  int m_change [2];
  int m_soda   [2];
  int m_rej    [2];
  int m_ncoin  [2];
  int m_coin   [2][16];

  function automatic int price(input int k);
    return (k == 0) ? 4 : 13;
  endfunction

  function automatic int coin_code(input int units);
    return (units == 5) ? 3 : (units == 2) ? 2 : (units == 1) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic load_coins(input int k, input int amt);
    int a;
    a = amt;
    m_ncoin[k] = 0;
    while (a > 0) begin
      m_coin[k][m_ncoin[k]] = (a >= 5) ? 5 : (a >= 2) ? 2 : 1;
      a -= m_coin[k][m_ncoin[k]];
      m_ncoin[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_credit[k] = 0; m_change[k] = 0; m_soda[k] = 0; m_rej[k] = 0; m_ncoin[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int n, val, sum, was_busy;
    n = int'(nickel) + int'(dime) + int'(quarter);
    val = (n != 1) ? 0 : nickel ? 1 : dime ? 2 : 5;
    was_busy = (m_soda[k] != 0 || m_ncoin[k] > 0) ? 1 : 0;
    m_rej[k] = was_busy ? int'(n > 0) : int'(n > 1);
    if (m_soda[k] != 0) begin
      m_soda[k] = 0;
      if (m_change[k] > 0) load_coins(k, m_change[k]);
      m_change[k] = 0;
    end else if (m_ncoin[k] > 0) begin
      if (disp_ready) begin
        for (int i = 0; i < 15; i++) m_coin[k][i] = m_coin[k][i+1];
        m_ncoin[k]--;
      end
    end else begin
      sum = m_credit[k] + val;
      if (cancel && sum > 0) begin
        load_coins(k, sum);
        m_credit[k] = 0;
      end else if (sum >= price(k)) begin
        m_soda[k]   = 1;
        m_change[k] = sum - price(k);
        m_credit[k] = 0;
      end else begin
        m_credit[k] = sum;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input int k, input int soda, input int change, input int credit,
                     input int busy, input int rej, input int dv, input int dc);
    string p;
    p = (k == 0) ? "p4" : "p13";
    chk({p, ".soda"}, soda, m_soda[k]);
    if (m_soda[k] != 0) chk({p, ".change"}, change, m_change[k]);
    chk({p, ".credit"}, credit, m_credit[k]);
    chk({p, ".busy"}, busy, int'(m_soda[k] != 0 || m_ncoin[k] > 0));
    chk({p, ".coin_rej"}, rej, m_rej[k]);
    chk({p, ".disp_valid"}, dv, int'(m_ncoin[k] > 0));
    chk({p, ".disp_coin"}, dc, (m_ncoin[k] > 0) ? coin_code(m_coin[k][0]) : 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0, int'(soda_a), int'(change_a), int'(credit_a), int'(busy_a), int'(rej_a), int'(dv_a), int'(dc_a));
      cmp(1, int'(soda_b), int'(change_b), int'(credit_b), int'(busy_b), int'(rej_b), int'(dv_b), int'(dc_b));
    end
  end

  task automatic step(input logic n, input logic d, input logic q, input logic c);
    nickel = n; dime = d; quarter = q; cancel = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    nickel = 0; dime = 0; quarter = 0; cancel = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".soda"}, int'(soda_a), 0);
    chk({tag, ".change"}, int'(change_a), 0);
    chk({tag, ".credit"}, int'(credit_a), 0);
    chk({tag, ".busy"}, int'(busy_a), 0);
    chk({tag, ".coin_rej"}, int'(rej_a), 0);
    chk({tag, ".disp_valid"}, int'(dv_a), 0);
    chk({tag, ".disp_coin"}, int'(dc_a), 0);
    chk({tag, ".b_disp_valid"}, int'(dv_b), 0);
    chk({tag, ".b_credit"}, int'(credit_b), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    nickel = 0; dime = 0; quarter = 0; cancel = 0; disp_ready = 1'b1;
    #2;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Dime, nickel, quarter at PRICE=4: change 4 returned as two dimes.
    step(0, 1, 0, 0); chk("t1.credit", int'(credit_a), 2);
    step(1, 0, 0, 0); chk("t1.credit2", int'(credit_a), 3);
    step(0, 0, 1, 0); chk("t1.soda", int'(soda_a), 1); chk("t1.change", int'(change_a), 4);
    step(0, 0, 0, 0); chk("t1.coin1", int'(dc_a), 2); chk("t1.valid1", int'(dv_a), 1);
    step(0, 0, 0, 0); chk("t1.coin2", int'(dc_a), 2);
    step(0, 0, 0, 0); chk("t1.idle", int'(busy_a), 0); chk("t1.valid_off", int'(dv_a), 0);

    // Nickel+quarter gives one dime; dime+quarter gives dime then nickel.
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); chk("t2.change2", int'(change_a), 2);
    step(0, 0, 0, 0); chk("t2.coin", int'(dc_a), 2);
    step(0, 0, 0, 0); chk("t2.idle", int'(busy_a), 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0); chk("t2.change3", int'(change_a), 3);
    step(0, 0, 0, 0); chk("t2.coin_dime", int'(dc_a), 2);
    step(0, 0, 0, 0); chk("t2.coin_nickel", int'(dc_a), 1);
    step(0, 0, 0, 0); chk("t2.idle2", int'(dv_a), 0);

    // Exact price: vend with zero change, straight back to idle.
    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); chk("t3.soda", int'(soda_a), 1); chk("t3.change0", int'(change_a), 0);
    step(0, 0, 0, 0); chk("t3.busy", int'(busy_a), 0); chk("t3.no_valid", int'(dv_a), 0);

    // PRICE=13 cancel after 7 units: quarter held through 3 stalled cycles, then dime.
    do_reset();
    step(0, 0, 1, 0);
    step(0, 1, 0, 0); chk("t4.credit", int'(credit_b), 7);
    disp_ready = 1'b0;
    step(0, 0, 0, 1); chk("t4.quarter", int'(dc_b), 3); chk("t4.valid", int'(dv_b), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0); chk("t4.hold", int'(dc_b), 3);
    end
    disp_ready = 1'b1;
    step(0, 0, 0, 0); chk("t4.dime", int'(dc_b), 2);
    step(0, 0, 0, 0); chk("t4.idle", int'(busy_b), 0); chk("t4.no_soda", int'(soda_b), 0);

    // Rejects: double strobe while collecting, cancel at zero, quarter while dispensing.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0); chk("t5.rej", int'(rej_a), 1); chk("t5.credit_kept", int'(credit_a), 1);
    step(0, 0, 0, 1); chk("t5.refund", int'(dc_a), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1); chk("t5.cancel0", int'(busy_a), 0);
    disp_ready = 1'b0;
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0); chk("t5.rej_disp", int'(rej_a), 1); chk("t5.credit0", int'(credit_a), 0);
    disp_ready = 1'b1;
    step(0, 0, 0, 0);

    // Asynchronous reset while a coin is on offer.
    do_reset();
    disp_ready = 1'b0;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0); chk("t6.offer", int'(dv_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6.async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    disp_ready = 1'b1;
    step(1, 0, 0, 0); chk("t6.credit", int'(credit_a), 1); chk("t6.no_offer", int'(dv_a), 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic n, d, q;
      r = $urandom_range(0, 9);
      n = (r == 0); d = (r == 1); q = (r == 2);
      if (r == 3) begin
        n = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); q = ~(n & d);
      end
      disp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      step(n, d, q, ($urandom_range(0, 15) == 0));
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
